// File: rtl/des_pkg.sv
// des_pkg: DES block geometry, IP/FP tables and output-buffer states shared by the DES stages.
package des_pkg;
  localparam int BLOCK_W = 64;
  localparam int HALF_W = 32;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  localparam int FP_TAB [BLOCK_W] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41, 9, 49, 17, 57, 25
  };
  localparam int IP_TAB [BLOCK_W] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };
  // DES bit n lives at vector index BLOCK_W-n
  function automatic logic [BLOCK_W-1:0] ip_perm(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    for (int i = 0; i < BLOCK_W; i++) y[BLOCK_W-1-i] = x[BLOCK_W-IP_TAB[i]];
    return y;
  endfunction
endpackage

// File: rtl/des_final_perm_if.sv
// des_final_perm_if: L16/R16 input handshake and ciphertext output handshake with completion status.
interface des_final_perm_if #(parameter int CNT_W = 16);
  logic in_valid;
  logic in_ready;
  logic [des_pkg::HALF_W-1:0] round_left;
  logic [des_pkg::HALF_W-1:0] round_right;
  logic out_valid;
  logic out_ready;
  logic [des_pkg::BLOCK_W-1:0] ciphertext;
  logic fFp;
  logic [CNT_W-1:0] block_count;
  modport master (
    output in_valid, round_left, round_right, out_ready,
    input in_ready, out_valid, ciphertext, fFp, block_count
  );
  modport slave (
    input in_valid, round_left, round_right, out_ready,
    output in_ready, out_valid, ciphertext, fFp, block_count
  );
endinterface

// File: rtl/des_fp_net.sv
// des_fp_net: combinational DES inverse initial permutation wiring.
module des_fp_net
  import des_pkg::*;
(
  input  logic [BLOCK_W-1:0] data,
  output logic [BLOCK_W-1:0] result
);
  for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
    assign result[BLOCK_W-1-i] = data[BLOCK_W-FP_TAB[i]];
  end
endmodule

// File: rtl/des_final_perm.sv
// des_final_perm: DES final swap + FP with a 2-entry output buffer, completion pulse and block counter.
module des_final_perm
  import des_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  des_final_perm_if.slave bus
);
  state_t state, state_nxt;
  logic [BLOCK_W-1:0] entry [DEPTH];
  logic [BLOCK_W-1:0] perm;
  logic [BLOCK_W-1:0] head_d;
  logic [CNT_W-1:0] count;
  logic done;
  logic acc, pop, head_we, tail_we;
  des_fp_net u_fp (
    .data({bus.round_right, bus.round_left}),
    .result(perm)
  );
  assign bus.in_ready = state != TWO;
  assign bus.out_valid = state != EMPTY;
  assign bus.ciphertext = entry[0];
  assign bus.fFp = done;
  assign bus.block_count = count;
  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else state <= state_nxt;
  end
  // accept+pop in ONE overwrites the head; pop in TWO promotes the tail
  always_comb begin
    state_nxt = acc && !pop ? (state == EMPTY ? ONE : TWO)
              : pop && !acc ? (state == TWO ? ONE : EMPTY) : state;
    head_we = (acc && (state == EMPTY || pop)) || (state == TWO && pop);
    tail_we = acc && !pop && state == ONE;
    head_d = state == TWO ? entry[1] : perm;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry <= '{default: '0};
      count <= '0;
      done <= 1'b0;
    end else begin
      if (head_we) entry[0] <= head_d;
      if (tail_we) entry[1] <= perm;
      if (pop) count <= count + CNT_W'(1);
      done <= pop;
    end
  end
endmodule

// File: doc/des_final_perm.md
# des_final_perm

Output stage of the DES datapath: takes the 16th-round halves (L16, R16) from the round engine, applies the final swap and the inverse initial permutation (IP⁻¹/FP), and returns the 64-bit ciphertext block. It is the counterpart of the IP input stage. It decouples the round engine from the ciphertext consumer with valid/ready handshakes on both sides and a 2-entry output buffer. It also emits a one-cycle completion flag and a running block count.

## Interface
- `DEPTH`, 2: output buffer entries. Fixed at 2; other values unsupported.
- `CNT_W`, 16: width of `block_count`.
- `clk`, in, 1: sole clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-low; clears all state immediately.
- `in_valid`, in, 1: round engine presents L16/R16.
- `in_ready`, out, 1: stage can accept.
- `round_left`, in, 32: L16.
- `round_right`, in, 32: R16.
- `out_valid`, out, 1: `ciphertext` holds a valid block.
- `out_ready`, in, 1: consumer takes the block.
- `ciphertext`, out, 64: FP result, bit 63 = DES bit 1.
- `fFp`, out, 1: one-cycle pulse per completed output handshake.
- `block_count`, out, CNT_W: number of output handshakes since reset.

## Operation
- Preoutput = {round_right, round_left}: the final swap. DES bit n maps to vector index 64−n.
- ciphertext = FP(preoutput), using the standard DES IP⁻¹ table. Row 1 is 40 8 48 16 56 24 64 32; row 8 is 33 1 41 9 49 17 57 25. Output bit i takes preoutput bit FP[i].
- Invariant: FP(IP(x)) = x for all 64-bit x, with IP as in the input stage.
- The permutation is applied on accept. The buffer stores permuted 64-bit words.
- Buffer FSM states:
  - EMPTY: `in_ready`=1, `out_valid`=0.
  - ONE: `in_ready`=1, `out_valid`=1.
  - TWO: `in_ready`=0, `out_valid`=1.
- Transitions (acc = in_valid&in_ready, pop = out_valid&out_ready):
  - EMPTY: acc → ONE.
  - ONE: acc&!pop → TWO; pop&!acc → EMPTY; acc&pop → ONE, with the head replaced by the new word.
  - TWO: pop → ONE, with the second entry promoted to head.
- `ciphertext` always shows the head entry. It is stable while `out_valid`=1 and `out_ready`=0.
- On pop: `fFp`=1 the next cycle, and `block_count` increments, wrapping from all-ones to 0.
- Inputs are ignored when `in_ready`=0. No overflow is possible.

## Timing
- Reset values: state EMPTY; `in_ready`=1 (combinational from state); `out_valid`=0; `ciphertext`=0; `fFp`=0; `block_count`=0.
- Latency: accept at edge k → `out_valid`=1 with the correct ciphertext after edge k (one cycle).
- Throughput: one block per cycle while `out_ready` is held high.
- `in_ready` and `out_valid` are derived only from registered state. There is no combinational path from `out_ready` to `in_ready`.
- Reset asserted mid-operation discards both entries and clears the counter. The first accept after reset release behaves as from EMPTY.
- A simultaneous accept and pop in ONE counts as one completion, and the new word is visible the next cycle.

## Structure
- Package `des_pkg`:
  - FP table as a 64-entry constant.
  - IP table, shared with the input stage.
  - Localparams for block width (64) and half width (32).
  - FSM state enum {EMPTY, ONE, TWO}.
- Sub-module `des_fp_net`: purely combinational 64-bit FP wiring, driven from the package table. It is reused by any later decrypt path.
- Top level: the FSM, the two 64-bit entry registers, the counter and the `fFp` register.

## Test plan
- Known answer: L16=32'h43423234, R16=32'h0A4CD995 → `ciphertext`=64'h85E813540F0AB405 one cycle after accept; `fFp` pulses on pop; `block_count`=1.
- Single bit: round_right=32'h80000000, round_left=0 → `ciphertext`=64'h0000000000000040. All zeros → 0; all ones → 64'hFFFFFFFFFFFFFFFF.
- Backpressure: hold `out_ready`=0 and offer 3 blocks → first two accepted, `in_ready`=0 after the second. Raise `out_ready` → outputs appear in order, third block accepted once the buffer reaches ONE, with no loss or duplication.
- Streaming: `in_valid`=`out_ready`=1 for 100 random blocks → one output per cycle; each output equals FP({R,L}); round-trip IP(ciphertext) = {R,L}; `block_count`=100.
- Reset mid-stream: assert `reset` low with state TWO → `out_valid`=0, `block_count`=0 and `in_ready`=1 asynchronously. Previously buffered blocks never appear.
- Counter wrap: preload by running 65535 blocks, then one more → `block_count` wraps from 16'hFFFF to 0 and `fFp` still pulses.
